// File: rtl/easyaxi_rd_arb_pkg.sv
// Common widths and helpers for the EASYAXI read arbiter, derived from the shared AXI defines.
`include "easyaxi_define.sv"

package easyaxi_rd_arb_pkg;

  localparam int ID_W    = `AXI_ID_W;
  localparam int ADDR_W  = `AXI_ADDR_W;
  localparam int LEN_W   = `AXI_LEN_W;
  localparam int SIZE_W  = `AXI_SIZE_W;
  localparam int BURST_W = `AXI_BURST_W;
  localparam int DATA_W  = `AXI_DATA_W;
  localparam int RESP_W  = `AXI_RESP_W;

  localparam logic [BURST_W-1:0] BURST_INCR  = `AXI_BURST_INCR;
  localparam logic [RESP_W-1:0]  RESP_OKAY   = `AXI_RESP_OKAY;
  localparam logic [RESP_W-1:0]  RESP_SLVERR = `AXI_RESP_SLVERR;

  // Next master index after idx, wrapping to 0 at num.
  function automatic int wrap_inc(input int idx, input int num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/easyaxi_arb_picker.sv
// Combinational request picker: round-robin from start when EASYAXI_RD_ARB_RR_EN is defined,
// lowest asserted index otherwise. Zero latency, no state.
module easyaxi_arb_picker #(
  parameter int NUM_MST   = 2,
  parameter int MST_IDX_W = 1
) (
  input  logic [NUM_MST-1:0]   req,
  input  logic [MST_IDX_W-1:0] start,
  output logic [MST_IDX_W-1:0] grant,
  output logic                 vld
);

`ifdef EASYAXI_RD_ARB_RR_EN
  // Walk offsets from the far end so the closest request to start is written last and wins.
  always_comb begin
    int idx;
    grant = '0;
    vld   = 1'b0;
    idx   = 0;
    for (int off = NUM_MST - 1; off >= 0; off--) begin
      idx = int'(start) + off;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      if (req[idx]) begin
        grant = MST_IDX_W'(idx);
        vld   = 1'b1;
      end
    end
  end
`else
  logic start_unused;
  assign start_unused = ^start;

  always_comb begin
    grant = '0;
    vld   = 1'b0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant = MST_IDX_W'(i);
        vld   = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/easyaxi_define.sv
// Shared EASYAXI channel widths and encodings; include-guarded so every user can pull it in.
`ifndef EASYAXI_DEFINE_SV
`define EASYAXI_DEFINE_SV

`define AXI_ID_W         4
`define AXI_ADDR_W       32
`define AXI_LEN_W        8
`define AXI_SIZE_W       3
`define AXI_BURST_W      2
`define AXI_DATA_W       32
`define AXI_RESP_W       2

`define AXI_BURST_FIXED  2'b00
`define AXI_BURST_INCR   2'b01
`define AXI_BURST_WRAP   2'b10

`define AXI_RESP_OKAY    2'b00
`define AXI_RESP_EXOKAY  2'b01
`define AXI_RESP_SLVERR  2'b10
`define AXI_RESP_DECERR  2'b11

`endif

// File: rtl/easyaxi_rd_arb.sv
// Shares one EASYAXI read slave among NUM_MST masters, one burst at a time; 1-cycle arbitration,
// AR/R paths combinational. Round-robin with EASYAXI_RD_ARB_RR_EN, fixed priority otherwise.
`include "easyaxi_define.sv"

module easyaxi_rd_arb
  import easyaxi_rd_arb_pkg::*;
#(
  parameter int NUM_MST   = 2,
  parameter int MST_IDX_W = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MST-1:0]          m_arvalid,
  output logic [NUM_MST-1:0]          m_arready,
  input  logic [NUM_MST*ID_W-1:0]     m_arid,
  input  logic [NUM_MST*ADDR_W-1:0]   m_araddr,
  input  logic [NUM_MST*LEN_W-1:0]    m_arlen,
  input  logic [NUM_MST*SIZE_W-1:0]   m_arsize,
  input  logic [NUM_MST*BURST_W-1:0]  m_arburst,
  output logic [NUM_MST-1:0]          m_rvalid,
  input  logic [NUM_MST-1:0]          m_rready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [RESP_W-1:0]           m_rresp,
  output logic                        m_rlast,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [ID_W-1:0]             s_arid,
  output logic [ADDR_W-1:0]           s_araddr,
  output logic [LEN_W-1:0]            s_arlen,
  output logic [SIZE_W-1:0]           s_arsize,
  output logic [BURST_W-1:0]          s_arburst,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [DATA_W-1:0]           s_rdata,
  input  logic [RESP_W-1:0]           s_rresp,
  input  logic                        s_rlast,
  output logic                        arb_busy,
  output logic [MST_IDX_W-1:0]        arb_grant
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    DATA = ST_DATA
  } state_e;

  state_e               state_r, state_nxt;
  logic [MST_IDX_W-1:0] grant_r, grant_nxt;
  logic [MST_IDX_W-1:0] pick_start, pick_idx;
  logic                 pick_vld;
  logic                 r_done;

  easyaxi_arb_picker #(
    .NUM_MST   (NUM_MST),
    .MST_IDX_W (MST_IDX_W)
  ) u_picker (
    .req   (m_arvalid),
    .start (pick_start),
    .grant (pick_idx),
    .vld   (pick_vld)
  );

  assign r_done = (state_r == DATA) && s_rvalid && m_rready[grant_r] && s_rlast;

`ifdef EASYAXI_RD_ARB_RR_EN
  logic [MST_IDX_W-1:0] rr_ptr_r, rr_ptr_nxt;

  always_comb begin
    rr_ptr_nxt = rr_ptr_r;
    if (r_done) rr_ptr_nxt = MST_IDX_W'(wrap_inc(int'(grant_r), NUM_MST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_r <= '0;
    else     rr_ptr_r <= rr_ptr_nxt;
  end

  assign pick_start = rr_ptr_r;
`else
  assign pick_start = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= '0;
    end else begin
      state_r <= state_nxt;
      grant_r <= grant_nxt;
    end
  end

  // Handshake qualifiers only open in the state that owns them; stray slave RVALID is ignored.
  always_comb begin
    state_nxt = state_r;
    grant_nxt = grant_r;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    case (state_r)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_idx;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        s_arvalid          = m_arvalid[grant_r];
        m_arready[grant_r] = s_arready;
        if (m_arvalid[grant_r] && s_arready) state_nxt = DATA;
      end
      DATA: begin
        m_rvalid[grant_r] = s_rvalid;
        s_rready          = m_rready[grant_r];
        if (r_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s_arid    = m_arid[int'(grant_r)*ID_W +: ID_W];
  assign s_araddr  = m_araddr[int'(grant_r)*ADDR_W +: ADDR_W];
  assign s_arlen   = m_arlen[int'(grant_r)*LEN_W +: LEN_W];
  assign s_arsize  = m_arsize[int'(grant_r)*SIZE_W +: SIZE_W];
  assign s_arburst = m_arburst[int'(grant_r)*BURST_W +: BURST_W];

  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;

  assign arb_busy  = (state_r != IDLE);
  assign arb_grant = grant_r;

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Directed bench for easyaxi_rd_arb: single burst, backpressure, contention, isolation,
// error response and mid-burst reset, each checked against hand-derived values.
module tb_easyaxi_rd_arb;
  import easyaxi_rd_arb_pkg::*;

  localparam int NM = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NM-1:0]           m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NM*ID_W-1:0]      m_arid;
  logic [NM*ADDR_W-1:0]    m_araddr;
  logic [NM*LEN_W-1:0]     m_arlen;
  logic [NM*SIZE_W-1:0]    m_arsize;
  logic [NM*BURST_W-1:0]   m_arburst;
  logic [DATA_W-1:0]       m_rdata;
  logic [RESP_W-1:0]       m_rresp;
  logic                    m_rlast;
  logic                    s_arvalid, s_arready;
  logic [ID_W-1:0]         s_arid;
  logic [ADDR_W-1:0]       s_araddr;
  logic [LEN_W-1:0]        s_arlen;
  logic [SIZE_W-1:0]       s_arsize;
  logic [BURST_W-1:0]      s_arburst;
  logic                    s_rvalid, s_rready;
  logic [DATA_W-1:0]       s_rdata;
  logic [RESP_W-1:0]       s_rresp;
  logic                    s_rlast;
  logic                    arb_busy;
  logic [0:0]              arb_grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  easyaxi_rd_arb #(.NUM_MST(NM), .MST_IDX_W(1)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast),
    .arb_busy(arb_busy), .arb_grant(arb_grant)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] bdat(input logic [ADDR_W-1:0] addr, input int k);
    return {addr[15:0], 16'(k)};
  endfunction

  task automatic set_req(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [LEN_W-1:0] len);
    m_arvalid[m]                      = 1'b1;
    m_arid[m*ID_W +: ID_W]            = id;
    m_araddr[m*ADDR_W +: ADDR_W]      = addr;
    m_arlen[m*LEN_W +: LEN_W]         = len;
    m_arsize[m*SIZE_W +: SIZE_W]      = 3'd2;
    m_arburst[m*BURST_W +: BURST_W]   = BURST_INCR;
  endtask

  // Expects master m to win the next arbitration, then plays slave for the whole burst.
  task automatic serve(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                       input logic [LEN_W-1:0] len, input int stall,
                       input logic [RESP_W-1:0] lresp, input string tag);
    int   cyc, beat, got, st;
    logic rdy;
    #1;
    cyc = 0;
    while (s_arvalid !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    chk({tag, ".ar_lat"},  cyc, 1);
    chk({tag, ".grant"},   arb_grant, m);
    chk({tag, ".arid"},    s_arid, id);
    chk({tag, ".araddr"},  s_araddr, addr);
    chk({tag, ".arlen"},   s_arlen, len);
    chk({tag, ".arburst"}, s_arburst, BURST_INCR);
    chk({tag, ".arready"}, m_arready, 64'(1 << m));
    chk({tag, ".busy"},    arb_busy, 1);
    step();
    m_arvalid[m] = 1'b0;
    beat = 0; got = 0; st = 0; cyc = 0;
    while (got <= int'(len) && cyc < 100) begin
      rdy         = !(beat == 2 && st < stall);
      s_rvalid    = 1'b1;
      s_rdata     = bdat(addr, beat);
      s_rlast     = (beat == int'(len));
      s_rresp     = (beat == int'(len)) ? lresp : RESP_OKAY;
      m_rready[m] = rdy;
      #1;
      chk({tag, ".rvalid"},   m_rvalid, 64'(1 << m));
      chk({tag, ".s_rready"}, s_rready, rdy);
      chk({tag, ".arrdy_d"},  m_arready, 0);
      chk({tag, ".rdata"},    m_rdata, bdat(addr, got));
      if (rdy) begin
        chk({tag, ".rlast"}, m_rlast, got == int'(len));
        chk({tag, ".rresp"}, m_rresp, (got == int'(len)) ? lresp : RESP_OKAY);
        got++;
      end
      step();
      if (rdy) beat++;
      else     st++;
      cyc++;
    end
    s_rvalid    = 1'b0;
    s_rlast     = 1'b0;
    m_rready[m] = 1'b1;
    #1;
    chk({tag, ".beats"}, got, int'(len) + 1);
    chk({tag, ".idle"},  arb_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int g;
    rst = 1'b1;
    m_arvalid = '0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_rready = '1; s_arready = 1'b1;
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
    #2;
    chk("rst.busy",      arb_busy, 0);
    chk("rst.grant",     arb_grant, 0);
    chk("rst.s_arvalid", s_arvalid, 0);
    chk("rst.m_arready", m_arready, 0);
    chk("rst.m_rvalid",  m_rvalid, 0);
    chk("rst.s_rready",  s_rready, 0);
    step();
    step();
    rst = 1'b0;

    set_req(0, 4'h1, 32'h100, 8'd3);
    serve(0, 4'h1, 32'h100, 8'd3, 0, RESP_OKAY, "single");

    set_req(1, 4'h4, 32'h140, 8'd3);
    serve(1, 4'h4, 32'h140, 8'd3, 5, RESP_OKAY, "bp");

    set_req(0, 4'h2, 32'h200, 8'd1);
    set_req(1, 4'h3, 32'h300, 8'd1);
    for (int k = 0; k < 4; k++) begin
`ifdef EASYAXI_RD_ARB_RR_EN
      g = k % 2;
`else
      g = 0;
`endif
      serve(g, (g == 1) ? 4'h3 : 4'h2, (g == 1) ? 32'h300 : 32'h200, 8'd1, 0, RESP_OKAY, "cont");
      set_req(g, (g == 1) ? 4'h3 : 4'h2, (g == 1) ? 32'h300 : 32'h200, 8'd1);
    end
    m_arvalid = '0;
    step();

    set_req(0, 4'h5, 32'h400, 8'd7);
    set_req(1, 4'hF, 32'h500, 8'd1);
    serve(0, 4'h5, 32'h400, 8'd7, 0, RESP_OKAY, "iso");
    serve(1, 4'hF, 32'h500, 8'd1, 0, RESP_SLVERR, "err");

    set_req(1, 4'h6, 32'h600, 8'd3);
    step();
    step();
    m_arvalid[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_rvalid = 1'b1;
      s_rdata  = bdat(32'h600, k);
      step();
    end
    s_rvalid = 1'b1;
    s_rdata  = bdat(32'h600, 2);
    #1;
    chk("mid.busy",  arb_busy, 1);
    chk("mid.grant", arb_grant, 1);
    rst = 1'b1;
    #1;
    chk("mrst.busy",      arb_busy, 0);
    chk("mrst.grant",     arb_grant, 0);
    chk("mrst.m_rvalid",  m_rvalid, 0);
    chk("mrst.s_rready",  s_rready, 0);
    chk("mrst.m_arready", m_arready, 0);
    chk("mrst.s_arvalid", s_arvalid, 0);
    step();
    chk("mrst.busy2", arb_busy, 0);
    s_rvalid = 1'b0;
    rst = 1'b0;
    set_req(1, 4'h7, 32'h700, 8'd2);
    serve(1, 4'h7, 32'h700, 8'd2, 0, RESP_OKAY, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
